id_stage: RTL and testbench

Instruction Decode stage of the five-stage ARM pipeline. It consumes the PC and instruction registered by the fetch-stage pipeline register and decodes them into execute-stage control. It reads operands from an internal 15-entry register file, which the write-back stage writes. All results are registered into the ID/EX pipeline register, so the block feeds the execute stage directly.

---
 rtl/arm_pkg.sv | 103 ++++++++++
 rtl/register_file.sv | 52 +++++
 rtl/id_stage.sv | 147 ++++++++++++++
 tb/tb_id_stage.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared ARM decode constants, ID/EX record types and condition evaluation
package arm_pkg;

    localparam logic [3:0] EXE_NOP = 4'b0000;
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    typedef enum logic [1:0] {
        MODE_DP  = 2'b00,
        MODE_MEM = 2'b01,
        MODE_BR  = 2'b10,
        MODE_UND = 2'b11
    } mode_e;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic [3:0] exe_cmd;
        logic       mem_r_en;
        logic       mem_w_en;
        logic       wb_en;
        logic       b;
        logic       s;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic        imm;
        logic [11:0] shift_operand;
        logic [23:0] signed_imm_24;
        logic [3:0]  dest;
        ctrl_t       ctrl;
    } idex_t;

    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] sr);
        logic n, z, c, v;
        n = sr[FLAG_N];
        z = sr[FLAG_Z];
        c = sr[FLAG_C];
        v = sr[FLAG_V];
        case (cond)
            COND_EQ: return z;
            COND_NE: return !z;
            COND_CS: return c;
            COND_CC: return !c;
            COND_MI: return n;
            COND_PL: return !n;
            COND_VS: return v;
            COND_VC: return !v;
            COND_HI: return c && !z;
            COND_LS: return !c || z;
            COND_GE: return n == v;
            COND_LT: return n != v;
            COND_GT: return !z && (n == v);
            COND_LE: return z || (n != v);
            COND_AL: return 1'b1;
            COND_NV: return 1'b0;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/register_file.sv
// rtl/register_file.sv - R0-R14 register file, 2 read / 1 write; REGFILE_BYPASS_EN enables write-through reads
module register_file
    import arm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic [3:0]  rd_addr1,
    input  logic [3:0]  rd_addr2,
    output logic [31:0] rd_data1,
    output logic [31:0] rd_data2,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [31:0] wr_data
);

    logic [31:0] regs_q [15];
    logic [31:0] regs_d [15];

    // R15 is not stored; it reads as the PC presented by fetch
    function automatic logic [31:0] read_port(input logic [3:0] addr);
        if (addr == 4'd15) begin
            return pc_in;
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (addr == wr_addr)) begin
            return wr_data;
        end
`endif
        return regs_q[addr];
    endfunction

    always_comb begin
        regs_d = regs_q;
        if (wr_en && (wr_addr != 4'd15)) begin
            regs_d[wr_addr] = wr_data;
        end
        rd_data1 = read_port(rd_addr1);
        rd_data2 = read_port(rd_addr2);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 15; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - ARM instruction decode, condition check and ID/EX register; REGFILE_BYPASS_EN selects regfile write-through
module id_stage
    import arm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic [31:0] instruction_in,
    input  logic        flush,
    input  logic        freeze,
    input  logic        hazard,
    input  logic [3:0]  sr_in,
    input  logic        wb_en_in,
    input  logic [3:0]  wb_dest,
    input  logic [31:0] wb_value,
    output logic [3:0]  src1,
    output logic [3:0]  src2,
    output logic        two_src,
    output logic [31:0] pc_out,
    output logic [31:0] val_rn,
    output logic [31:0] val_rm,
    output logic        imm,
    output logic [11:0] shift_operand,
    output logic [23:0] signed_imm_24,
    output logic [3:0]  dest,
    output logic [3:0]  exe_cmd,
    output logic        mem_r_en,
    output logic        mem_w_en,
    output logic        wb_en,
    output logic        b,
    output logic        s
);

    mode_e       mode;
    logic [3:0]  opcode;
    logic        is_store;
    ctrl_t       ctrl_dec;
    ctrl_t       ctrl_cond;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    idex_t       idex_d;
    idex_t       idex_q;

    assign mode     = mode_e'(instruction_in[27:26]);
    assign opcode   = instruction_in[24:21];
    assign is_store = (mode == MODE_MEM) && !instruction_in[20];
    assign src1     = instruction_in[19:16];
    assign src2     = is_store ? instruction_in[15:12] : instruction_in[3:0];
    // Uses the decode before the condition gate so the hazard unit sees a stable answer
    assign two_src  = !instruction_in[25] || ctrl_dec.mem_w_en;

    register_file u_register_file (
        .clk      (clk),
        .rst      (rst),
        .pc_in    (pc_in),
        .rd_addr1 (src1),
        .rd_addr2 (src2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .wr_en    (wb_en_in),
        .wr_addr  (wb_dest),
        .wr_data  (wb_value)
    );

    always_comb begin
        ctrl_dec = '0;
        case (mode)
            MODE_DP: begin
                ctrl_dec.s     = instruction_in[20];
                ctrl_dec.wb_en = 1'b1;
                case (opcode)
                    OP_MOV: ctrl_dec.exe_cmd = EXE_MOV;
                    OP_MVN: ctrl_dec.exe_cmd = EXE_MVN;
                    OP_ADD: ctrl_dec.exe_cmd = EXE_ADD;
                    OP_ADC: ctrl_dec.exe_cmd = EXE_ADC;
                    OP_SUB: ctrl_dec.exe_cmd = EXE_SUB;
                    OP_SBC: ctrl_dec.exe_cmd = EXE_SBC;
                    OP_AND: ctrl_dec.exe_cmd = EXE_AND;
                    OP_ORR: ctrl_dec.exe_cmd = EXE_ORR;
                    OP_EOR: ctrl_dec.exe_cmd = EXE_EOR;
                    OP_CMP: begin
                        ctrl_dec.exe_cmd = EXE_SUB;
                        ctrl_dec.wb_en   = 1'b0;
                        ctrl_dec.s       = 1'b1;
                    end
                    OP_TST: begin
                        ctrl_dec.exe_cmd = EXE_AND;
                        ctrl_dec.wb_en   = 1'b0;
                        ctrl_dec.s       = 1'b1;
                    end
                    default: begin
                        ctrl_dec.exe_cmd = EXE_NOP;
                        ctrl_dec.wb_en   = 1'b0;
                    end
                endcase
            end
            MODE_MEM: begin
                ctrl_dec.exe_cmd  = EXE_ADD;
                ctrl_dec.mem_r_en = instruction_in[20];
                ctrl_dec.mem_w_en = !instruction_in[20];
                ctrl_dec.wb_en    = instruction_in[20];
            end
            MODE_BR:  ctrl_dec.b = 1'b1;
            default:  ctrl_dec = '0;
        endcase
        ctrl_cond = cond_pass(instruction_in[31:28], sr_in) ? ctrl_dec : '0;
    end

    always_comb begin
        idex_d = idex_q;
        if (flush) begin
            idex_d = '0;
        end else if (!freeze) begin
            idex_d.pc            = pc_in;
            idex_d.val_rn        = rd_data1;
            idex_d.val_rm        = rd_data2;
            idex_d.imm           = instruction_in[25];
            idex_d.shift_operand = instruction_in[11:0];
            idex_d.signed_imm_24 = instruction_in[23:0];
            idex_d.dest          = instruction_in[15:12];
            idex_d.ctrl          = hazard ? '0 : ctrl_cond;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign pc_out        = idex_q.pc;
    assign val_rn        = idex_q.val_rn;
    assign val_rm        = idex_q.val_rm;
    assign imm           = idex_q.imm;
    assign shift_operand = idex_q.shift_operand;
    assign signed_imm_24 = idex_q.signed_imm_24;
    assign dest          = idex_q.dest;
    assign exe_cmd       = idex_q.ctrl.exe_cmd;
    assign mem_r_en      = idex_q.ctrl.mem_r_en;
    assign mem_w_en      = idex_q.ctrl.mem_w_en;
    assign wb_en         = idex_q.ctrl.wb_en;
    assign b             = idex_q.ctrl.b;
    assign s             = idex_q.ctrl.s;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - scoreboard bench for id_stage; honours REGFILE_BYPASS_EN
module tb_id_stage;

    logic        clk;
    logic        rst = 1'b1;
    logic [31:0] pc_in = '0;
    logic [31:0] instruction_in = '0;
    logic        flush = 1'b0;
    logic        freeze = 1'b0;
    logic        hazard = 1'b0;
    logic [3:0]  sr_in = '0;
    logic        wb_en_in = 1'b0;
    logic [3:0]  wb_dest = '0;
    logic [31:0] wb_value = '0;
    logic [3:0]  src1, src2;
    logic        two_src;
    logic [31:0] pc_out, val_rn, val_rm;
    logic        imm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [3:0]  dest, exe_cmd;
    logic        mem_r_en, mem_w_en, wb_en, b, s;

    // ctl = {exe_cmd, mem_r_en, mem_w_en, wb_en, b, s}
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rn;
        logic [31:0] rm;
        logic        imm;
        logic [11:0] shop;
        logic [23:0] simm;
        logic [3:0]  dest;
        logic [8:0]  ctl;
    } exp_t;

    exp_t        got;
    exp_t        exp_q[$];
    exp_t        last_exp;
    exp_t        e;
    logic [31:0] rf [15];
    logic [31:0] pc_gen;
    int          n_vec = 0;
    int          n_err = 0;

    localparam logic [8:0] C_MOV = 9'b0001_00100;
    localparam logic [8:0] C_ADD = 9'b0010_00100;
    localparam logic [8:0] C_B   = 9'b0000_00010;

    assign got = {pc_out, val_rn, val_rm, imm, shift_operand, signed_imm_24, dest,
                  exe_cmd, mem_r_en, mem_w_en, wb_en, b, s};

    id_stage dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .instruction_in(instruction_in),
        .flush(flush), .freeze(freeze), .hazard(hazard), .sr_in(sr_in),
        .wb_en_in(wb_en_in), .wb_dest(wb_dest), .wb_value(wb_value),
        .src1(src1), .src2(src2), .two_src(two_src), .pc_out(pc_out),
        .val_rn(val_rn), .val_rm(val_rm), .imm(imm), .shift_operand(shift_operand),
        .signed_imm_24(signed_imm_24), .dest(dest), .exe_cmd(exe_cmd),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en), .b(b), .s(s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rf_read(input logic [3:0] a, input logic [31:0] pc,
                                            input logic we, input logic [3:0] wd, input logic [31:0] wv);
        if (a == 4'd15) return pc;
`ifdef REGFILE_BYPASS_EN
        if (we && wd == a) return wv;
`endif
        return rf[a];
    endfunction

    // ARM-style: pairs of codes share a base test, odd codes invert it
    function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] sr);
        logic r;
        case (cond[3:1])
            3'd0: r = sr[2];
            3'd1: r = sr[1];
            3'd2: r = sr[3];
            3'd3: r = sr[0];
            3'd4: r = sr[1] & ~sr[2];
            3'd5: r = (sr[3] == sr[0]);
            3'd6: r = ~sr[2] & (sr[3] == sr[0]);
            default: r = 1'b1;
        endcase
        if (cond[0]) r = (cond[3:1] == 3'd7) ? 1'b0 : ~r;
        return r;
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [3:0] sr, input logic [8:0] ctl,
                         input logic [2:0] ffh, input logic we, input logic [3:0] wd, input logic [31:0] wv);
        exp_t x;
        logic [3:0] a2;
        pc_gen = pc_gen + 32'd4;
        a2 = (ins[27:26] == 2'b01 && !ins[20]) ? ins[15:12] : ins[3:0];
        x.pc   = pc_gen;
        x.rn   = rf_read(ins[19:16], pc_gen, we, wd, wv);
        x.rm   = rf_read(a2, pc_gen, we, wd, wv);
        x.imm  = ins[25];
        x.shop = ins[11:0];
        x.simm = ins[23:0];
        x.dest = ins[15:12];
        x.ctl  = ffh[0] ? 9'd0 : ctl;
        if (ffh[2]) x = '0;
        else if (ffh[1]) x = last_exp;
        last_exp = x;
        exp_q.push_back(x);
        instruction_in = ins; pc_in = pc_gen; sr_in = sr;
        flush = ffh[2]; freeze = ffh[1]; hazard = ffh[0];
        wb_en_in = we; wb_dest = wd; wb_value = wv;
        if (we && wd != 4'd15) rf[wd] = wv;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 15; i++) rf[i] = '0;
        last_exp = '0;
    endtask

    task automatic test_reset();
        pc_gen = 32'h100;
        clear_model();
        instruction_in = 32'hE3A01005;
        #1 rst = 1'b0;
        #1;
        n_vec++;
        if (got !== '0) begin n_err++; $display("FAIL reset_async got=%h exp=0", got); end
        @(posedge clk); @(negedge clk);
        n_vec++;
        if (got !== '0) begin n_err++; $display("FAIL reset_hold got=%h exp=0", got); end
        rst = 1'b1;
    endtask

    task automatic test_decode();
        logic [31:0] ins;
        logic [8:0]  ctl;
        logic [3:0]  s2;
        logic        two;
        for (int i = 0; i < 18; i++) begin
            case (i)
                0:  begin ins = 32'hE3A01005; ctl = C_MOV;        s2 = 4'd5; two = 1'b0; end
                1:  begin ins = 32'hE3F01000; ctl = 9'b1001_00101; s2 = 4'd0; two = 1'b0; end
                2:  begin ins = 32'hE0802001; ctl = C_ADD;        s2 = 4'd1; two = 1'b1; end
                3:  begin ins = 32'hE1500001; ctl = 9'b0100_00001; s2 = 4'd1; two = 1'b1; end
                4:  begin ins = 32'hE1400001; ctl = 9'b0100_00001; s2 = 4'd1; two = 1'b1; end
                5:  begin ins = 32'hE1100001; ctl = 9'b0110_00001; s2 = 4'd1; two = 1'b1; end
                6:  begin ins = 32'hE0612003; ctl = 9'b0000_00000; s2 = 4'd3; two = 1'b1; end
                7:  begin ins = 32'hE5901000; ctl = 9'b0010_10100; s2 = 4'd0; two = 1'b1; end
                8:  begin ins = 32'hE5801000; ctl = 9'b0010_01000; s2 = 4'd1; two = 1'b1; end
                9:  begin ins = 32'hEA000003; ctl = C_B;          s2 = 4'd3; two = 1'b0; end
                10: begin ins = 32'hEC000000; ctl = 9'b0000_00000; s2 = 4'd0; two = 1'b1; end
                11: begin ins = 32'hE2012003; ctl = 9'b0110_00100; s2 = 4'd3; two = 1'b0; end
                12: begin ins = 32'hE1812003; ctl = 9'b0111_00100; s2 = 4'd3; two = 1'b1; end
                13: begin ins = 32'hE0212003; ctl = 9'b1000_00100; s2 = 4'd3; two = 1'b1; end
                14: begin ins = 32'hE0412003; ctl = 9'b0100_00100; s2 = 4'd3; two = 1'b1; end
                15: begin ins = 32'hE0A12003; ctl = 9'b0011_00100; s2 = 4'd3; two = 1'b1; end
                16: begin ins = 32'hE0C12003; ctl = 9'b0101_00100; s2 = 4'd3; two = 1'b1; end
                default: begin ins = 32'hE7801000; ctl = 9'b0010_01000; s2 = 4'd1; two = 1'b1; end
            endcase
            drive(ins, 4'b0000, ctl, 3'b000, 1'b0, 4'd0, 32'd0);
            #1;
            n_vec++;
            if ({src1, src2, two_src} !== {ins[19:16], s2, two}) begin
                n_err++;
                $display("FAIL decode_src[%0d] got=%h exp=%h", i, {src1, src2, two_src}, {ins[19:16], s2, two});
            end
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front();
            n_vec++;
            if (got !== e) begin n_err++; $display("FAIL decode[%0d] got=%h exp=%h", i, got, e); end
        end
    endtask

    task automatic test_regfile();
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: drive(32'hEC000000, 4'b0000, 9'd0, 3'b000, 1'b1, 4'd0, 32'd3);
                1: drive(32'hEC000000, 4'b0000, 9'd0, 3'b000, 1'b1, 4'd1, 32'd4);
                2: drive(32'hE0802001, 4'b0000, C_ADD, 3'b000, 1'b0, 4'd0, 32'd0);
                default: drive(32'hE08F2001, 4'b0000, C_ADD, 3'b000, 1'b0, 4'd0, 32'd0);
            endcase
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front();
            n_vec++;
            if (got !== e) begin n_err++; $display("FAIL regfile[%0d] got=%h exp=%h", k, got, e); end
            if (k == 2) begin
                n_vec++;
                if ({val_rn, val_rm} !== {32'd3, 32'd4}) begin
                    n_err++; $display("FAIL regfile_add got=%h,%h exp=3,4", val_rn, val_rm);
                end
            end
        end
    endtask

    task automatic test_write_through();
        logic [31:0] want;
`ifdef REGFILE_BYPASS_EN
        want = 32'hDEADBEEF;
`else
        want = 32'd4;
`endif
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: drive(32'hE0802001, 4'b0000, C_ADD, 3'b000, 1'b1, 4'd1, 32'hDEADBEEF);
                1: drive(32'hE0802001, 4'b0000, C_ADD, 3'b000, 1'b1, 4'd15, 32'h55);
                2: drive(32'hE0802001, 4'b0000, C_ADD, 3'b000, 1'b0, 4'd0, 32'd0);
                default: drive(32'hE08F2001, 4'b0000, C_ADD, 3'b000, 1'b1, 4'd15, 32'h66);
            endcase
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front();
            n_vec++;
            if (got !== e) begin n_err++; $display("FAIL write_through[%0d] got=%h exp=%h", k, got, e); end
            if (k == 0) begin
                n_vec++;
                if (val_rm !== want) begin n_err++; $display("FAIL wt_rm got=%h exp=%h", val_rm, want); end
            end
        end
    endtask

    task automatic test_condition();
        logic [3:0]  sr;
        logic [31:0] ins;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: drive(32'h0A000003, 4'b0000, 9'd0, 3'b000, 1'b0, 4'd0, 32'd0);
                1: drive(32'h0A000003, 4'b0100, C_B, 3'b000, 1'b0, 4'd0, 32'd0);
                default: drive(32'h03A01005, 4'b0000, 9'd0, 3'b000, 1'b0, 4'd0, 32'd0);
            endcase
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front();
            n_vec++;
            if (got !== e) begin n_err++; $display("FAIL cond[%0d] got=%h exp=%h", k, got, e); end
            if (k == 1) begin
                n_vec++;
                if ({b, signed_imm_24} !== {1'b1, 24'h000003}) begin
                    n_err++; $display("FAIL beq_taken got=%h exp=1000003", {b, signed_imm_24});
                end
            end
        end
        for (int c = 0; c < 16; c++) begin
            for (int r = 0; r < 3; r++) begin
                sr = 4'($urandom_range(0, 15));
                ins = {c[3:0], 28'hA000003};
                drive(ins, sr, cond_ok(c[3:0], sr) ? C_B : 9'd0, 3'b000, 1'b0, 4'd0, 32'd0);
                @(posedge clk); @(negedge clk);
                e = exp_q.pop_front();
                n_vec++;
                if (got !== e) begin
                    n_err++; $display("FAIL cond_sweep c=%0d sr=%b got=%h exp=%h", c, sr, got, e);
                end
            end
        end
    endtask

    task automatic test_priority();
        for (int k = 0; k < 8; k++) begin
            case (k)
                0: drive(32'hE3A01005, 4'b0000, C_MOV, 3'b000, 1'b0, 4'd0, 32'd0);
                1: drive(32'hE0802001, 4'b0000, C_ADD, 3'b010, 1'b0, 4'd0, 32'd0);
                2: drive(32'hE0802001, 4'b0000, C_ADD, 3'b110, 1'b0, 4'd0, 32'd0);
                3: drive(32'hE0802001, 4'b0000, C_ADD, 3'b000, 1'b0, 4'd0, 32'd0);
                4: drive(32'hE3A01005, 4'b0000, C_MOV, 3'b001, 1'b0, 4'd0, 32'd0);
                5: drive(32'hE0802001, 4'b0000, C_ADD, 3'b011, 1'b1, 4'd3, 32'd77);
                6: drive(32'hE0802003, 4'b0000, C_ADD, 3'b000, 1'b0, 4'd0, 32'd0);
                default: drive(32'hE0802003, 4'b0000, C_ADD, 3'b100, 1'b0, 4'd0, 32'd0);
            endcase
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front();
            n_vec++;
            if (got !== e) begin n_err++; $display("FAIL priority[%0d] got=%h exp=%h", k, got, e); end
            if (k == 1) begin
                n_vec++;
                if (exe_cmd !== 4'b0001) begin n_err++; $display("FAIL freeze_hold got=%b exp=0001", exe_cmd); end
            end
            if (k == 2) begin
                n_vec++;
                if (got !== '0) begin n_err++; $display("FAIL flush_freeze got=%h exp=0", got); end
            end
            if (k == 4) begin
                n_vec++;
                if ({exe_cmd, wb_en, pc_out} !== {4'b0000, 1'b0, pc_gen}) begin
                    n_err++; $display("FAIL hazard got=%h exp=%h", {exe_cmd, wb_en, pc_out}, {5'b0, pc_gen});
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(32'hE3A01005, 4'b0000, C_MOV, 3'b000, 1'b1, 4'd2, 32'h1234);
        @(posedge clk); @(negedge clk);
        e = exp_q.pop_front();
        n_vec++;
        if (got !== e) begin n_err++; $display("FAIL pre_reset got=%h exp=%h", got, e); end
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if (got !== '0) begin n_err++; $display("FAIL reset_mid got=%h exp=0", got); end
        clear_model();
        @(negedge clk);
        rst = 1'b1;
        drive(32'hE0812002, 4'b0000, C_ADD, 3'b000, 1'b0, 4'd0, 32'd0);
        @(posedge clk); @(negedge clk);
        e = exp_q.pop_front();
        n_vec++;
        if (got !== e) begin n_err++; $display("FAIL post_reset got=%h exp=%h", got, e); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_regfile();
        test_write_through();
        test_condition();
        test_priority();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
